// File: rtl/riscv_timer.sv
// rtl/riscv_timer.sv - RISC-V machine timer (mtime/mtimecmp) on the memory-stage load/store path.
// Optional halt input enabled by defining RISCV_TIMER_HALT_EN.
module riscv_timer #(
  parameter int unsigned PRESCALE      = 1,
  parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000
) (
  input  logic        i_riscv_timer_clk,
  input  logic        i_riscv_timer_rst,
  input  logic [63:0] i_riscv_timer_addr,
  input  logic [63:0] i_riscv_timer_wdata,
  input  logic        i_riscv_timer_wren,
  input  logic        i_riscv_timer_rden,
  input  logic [1:0]  i_riscv_timer_storesrc,
  input  logic [2:0]  i_riscv_timer_memext,
`ifdef RISCV_TIMER_HALT_EN
  input  logic        i_riscv_timer_halt,
`endif
  output logic [63:0] o_riscv_timer_rdata,
  output logic        o_riscv_timer_rden,
  output logic        o_riscv_timer_irq
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_inc, sel_reg;
  logic [31:0] sel_word;
  logic        hit_mtime, hit_cmp, hit, halt, tick;
  logic        store_full, store_word;
  logic [1:0]  unused_addr_lsbs;

  assign unused_addr_lsbs = i_riscv_timer_addr[1:0];

`ifdef RISCV_TIMER_HALT_EN
  assign halt = i_riscv_timer_halt;
`else
  assign halt = 1'b0;
`endif

  assign hit_mtime = (i_riscv_timer_addr[63:3] == MTIME_ADDR[63:3]);
  assign hit_cmp   = (i_riscv_timer_addr[63:3] == MTIMECMP_ADDR[63:3]);
  assign hit       = hit_mtime | hit_cmp;

  assign o_riscv_timer_rden = i_riscv_timer_rden & hit;

  // Loads see the pre-edge register values, so a same-cycle store is invisible here.
  assign sel_reg  = hit_mtime ? mtime_q : mtimecmp_q;
  assign sel_word = i_riscv_timer_addr[2] ? sel_reg[63:32] : sel_reg[31:0];

  always_comb begin
    o_riscv_timer_rdata = 64'h0;
    if (hit) begin
      case (i_riscv_timer_memext)
        3'b011:  o_riscv_timer_rdata = sel_reg;
        3'b010:  o_riscv_timer_rdata = {{32{sel_word[31]}}, sel_word};
        3'b110:  o_riscv_timer_rdata = {32'h0, sel_word};
        default: o_riscv_timer_rdata = 64'h0;
      endcase
    end
  end

  assign tick      = !halt && (presc_q == PRESC_MAX);
  assign presc_d   = halt ? presc_q : (tick ? 16'h0 : presc_q + 16'd1);
  assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

  assign store_full = i_riscv_timer_wren && (i_riscv_timer_storesrc == 2'b11);
  assign store_word = i_riscv_timer_wren && (i_riscv_timer_storesrc == 2'b10);

  // A store to mtime wins over the increment; the untouched word keeps its pre-increment value.
  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    if (hit_mtime && store_full)
      mtime_d = i_riscv_timer_wdata;
    else if (hit_mtime && store_word)
      mtime_d = i_riscv_timer_addr[2] ? {i_riscv_timer_wdata[31:0], mtime_q[31:0]}
                                      : {mtime_q[63:32], i_riscv_timer_wdata[31:0]};
    if (hit_cmp && store_full)
      mtimecmp_d = i_riscv_timer_wdata;
    else if (hit_cmp && store_word)
      mtimecmp_d = i_riscv_timer_addr[2] ? {i_riscv_timer_wdata[31:0], mtimecmp_q[31:0]}
                                         : {mtimecmp_q[63:32], i_riscv_timer_wdata[31:0]};
  end

  always_ff @(posedge i_riscv_timer_clk or posedge i_riscv_timer_rst) begin
    if (i_riscv_timer_rst) begin
      presc_q           <= 16'h0;
      mtime_q           <= 64'h0;
      mtimecmp_q        <= 64'hFFFF_FFFF_FFFF_FFFF;
      o_riscv_timer_irq <= 1'b0;
    end else begin
      presc_q           <= presc_d;
      mtime_q           <= mtime_d;
      mtimecmp_q        <= mtimecmp_d;
      o_riscv_timer_irq <= (mtime_d >= mtimecmp_d);
    end
  end

endmodule
